// File: rtl/seq_ctrl.sv
// Simon Says game sequencer: grows a pseudo-random 2-bit sequence in memory,
// plays it back on the display and checks player presses against readback.
module seq_ctrl #(
  parameter int         MAX_LEN     = 11,
  parameter int         SHOW_CYCLES = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_num,
  output logic [3:0] mem_address,
  output logic       mem_rw,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  output logic       show_valid,
  output logic [1:0] show_num,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ?
                        SHOW_CYCLES : GAP_CYCLES;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST    = 4'(MAX_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GEN, S_PLAY_RD, S_PLAY_WAIT, S_SHOW,
    S_GAP, S_IN_RD, S_INPUT, S_WIN, S_LOSE
  } state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_nxt;
  logic [3:0]    len;
  logic [3:0]    idx;
  logic [TW-1:0] timer;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_nxt = {lfsr[6:0],
                     lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  function automatic logic [3:0] lvl(input logic [3:0] n);
    return (n == 4'd15) ? 4'd15 : n + 4'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      len         <= '0;
      idx         <= '0;
      timer       <= '0;
      mem_address <= '0;
      mem_rw      <= 1'b0;
      mem_wdata   <= '0;
      show_valid  <= 1'b0;
      show_num    <= '0;
      level       <= '0;
      busy        <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      lfsr   <= lfsr_nxt;
      mem_rw <= 1'b0;
      unique case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            win         <= 1'b0;
            lose        <= 1'b0;
            len         <= '0;
            idx         <= '0;
            busy        <= 1'b1;
            level       <= 4'd1;
            mem_rw      <= 1'b1;
            mem_address <= '0;
            mem_wdata   <= lfsr_nxt[1:0];
            state       <= S_GEN;
          end
        end
        S_GEN: begin
          idx         <= '0;
          mem_address <= '0;
          state       <= S_PLAY_RD;
        end
        S_PLAY_RD: state <= S_PLAY_WAIT;
        S_PLAY_WAIT: begin
          show_valid <= 1'b1;
          show_num   <= mem_rdata;
          timer      <= SHOW_LD;
          state      <= S_SHOW;
        end
        S_SHOW: begin
          if (timer == '0) begin
            show_valid <= 1'b0;
            show_num   <= '0;
            timer      <= GAP_LD;
            state      <= S_GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (idx == len) begin
            idx         <= '0;
            mem_address <= '0;
            state       <= S_IN_RD;
          end else begin
            idx         <= idx + 4'd1;
            mem_address <= idx + 4'd1;
            state       <= S_PLAY_RD;
          end
        end
        S_IN_RD: state <= S_INPUT;
        S_INPUT: begin
          // readback for idx is stable here because the address is held
          if (btn_valid) begin
            if (btn_num != mem_rdata) begin
              lose  <= 1'b1;
              busy  <= 1'b0;
              state <= S_LOSE;
            end else if (idx != len) begin
              idx         <= idx + 4'd1;
              mem_address <= idx + 4'd1;
              state       <= S_IN_RD;
            end else if (len == LAST) begin
              win   <= 1'b1;
              busy  <= 1'b0;
              state <= S_WIN;
            end else begin
              len         <= len + 4'd1;
              level       <= lvl(len + 4'd1);
              mem_rw      <= 1'b1;
              mem_address <= len + 4'd1;
              mem_wdata   <= lfsr_nxt[1:0];
              state       <= S_GEN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
